// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Debounces a bank of ten slide switches. Each raw level is synchronized into
// the clk domain, then sampled once per shared tick. A bit only moves to a new
// level after STABLE_TICKS consecutive sampled ticks disagree with the current
// debounced level. All bits that flip on the same tick form one commit event,
// reported by a one-cycle strobe together with a mask of the bits that moved.
//
// The first tick after reset is a priming tick: the debounced levels are
// loaded straight from the synchronized inputs so downstream logic never sees
// a spurious "change" caused by the power-up state of the switches.
//
// Parameters
//   TICK_CYCLES   clk cycles per sample tick (2 .. 2^20)
//   STABLE_TICKS  consecutive differing ticks needed to accept a level (2..255)
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   sw_raw        raw switch levels, asynchronous to clk
//   sw_stable     debounced switch levels (registered)
//   ready         high once sw_stable holds a real sample after reset
//   change_pulse  one-cycle strobe on every commit event
//   change_mask   bits that flipped on the last commit, held until the next
//   multi_change  more than one bit set in change_mask, held with it
//   event_count   number of change_pulse strobes since reset, wraps 255 -> 0
// ---------------------------------------------------------------------------
module sw_debounce #(
   parameter int unsigned TICK_CYCLES  = 50000,
   parameter int unsigned STABLE_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] sw_raw,
   output logic [9:0] sw_stable,
   output logic       ready,
   output logic       change_pulse,
   output logic [9:0] change_mask,
   output logic       multi_change,
   output logic [7:0] event_count
);

   localparam int unsigned        TICK_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [7:0]         CNT_LAST  = 8'(STABLE_TICKS - 1);

   // ------------------------------------------------------------------------
   // Reset release synchronizer. Assertion is immediate; release reaches the
   // tick counter only after two clean clk edges so the counter never starts
   // on a metastable reset edge.
   // ------------------------------------------------------------------------
   logic [1:0] rst_sync;
   logic       run_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         // NOTE: registers are assigned with <= so every flop samples the
         // pre-edge value of its neighbours; = here would collapse the chain.
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run_en = rst_sync[1];

   // ------------------------------------------------------------------------
   // Two-flop input synchronizer; only sync_q2 is used downstream.
   // ------------------------------------------------------------------------
   logic [9:0] sync_q1;
   logic [9:0] sync_q2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= sw_raw;
         sync_q2 <= sync_q1;
      end
   end

   // ------------------------------------------------------------------------
   // Shared sample tick: counter runs 0..TICK_CYCLES-1, tick is the single
   // cycle spent at the top value.
   // ------------------------------------------------------------------------
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (run_en) begin
         if (tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-bit disagreement counters. cnt[i] holds how many consecutive ticks
   // have seen sync_q2[i] differ from sw_stable[i]; reaching CNT_LAST with
   // another differing tick commits the bit.
   // ------------------------------------------------------------------------
   logic [9:0][7:0] cnt;
   logic [9:0][7:0] cnt_next;
   logic [9:0]      commit_vec;
   logic            sample_en;

   // Counters only advance once the priming sample has been taken.
   assign sample_en = tick && ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      cnt_next   = cnt;
      commit_vec = '0;
      for (int i = 0; i < 10; i++) begin
         if (sample_en) begin
            if (sync_q2[i] == sw_stable[i]) begin
               cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               commit_vec[i] = 1'b1;
               cnt_next[i]   = '0;
            end else begin
               cnt_next[i] = cnt[i] + 8'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Debounced state and commit reporting. sw_stable, change_mask,
   // multi_change and change_pulse all move on the same edge so a consumer
   // qualifying on change_pulse sees the matching data.
   // ------------------------------------------------------------------------
   logic [9:0] commit_low;
   logic       commit_multi;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign commit_low   = commit_vec & (commit_vec - 10'd1);
   assign commit_multi = |commit_low;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the per-bit counter array is reset like any other register;
         // an aborted count must never survive into the next run.
         cnt          <= '0;
         sw_stable    <= '0;
         ready        <= 1'b0;
         change_pulse <= 1'b0;
         change_mask  <= '0;
         multi_change <= 1'b0;
         event_count  <= '0;
      end else begin
         cnt          <= cnt_next;
         change_pulse <= 1'b0;
         if (tick && !ready) begin
            // Priming tick: adopt whatever the switches read, silently.
            sw_stable <= sync_q2;
            ready     <= 1'b1;
         end else if (|commit_vec) begin
            sw_stable    <= sw_stable ^ commit_vec;
            change_mask  <= commit_vec;
            multi_change <= commit_multi;
            change_pulse <= 1'b1;
            event_count  <= event_count + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Protocol properties: a strobe is one cycle wide and only follows priming.
   // ------------------------------------------------------------------------
   a_pulse_single : assert property (@(posedge clk) disable iff (!reset_n)
      change_pulse |=> !change_pulse);

   a_pulse_ready : assert property (@(posedge clk) disable iff (!reset_n)
      change_pulse |-> ready);

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//
// Bench for sw_debounce with TICK_CYCLES=4, STABLE_TICKS=3. A behavioural
// reference runs alongside the DUT: it tracks raw input history, places ticks
// by arithmetic from the reset release, and applies the debounce rules per
// bit with plain integer run lengths. Every cycle the DUT outputs are compared
// to it. Directed vectors come from a table of hand-derived expectations, and
// the multi-cycle corners (bounce, reset mid-count, counter wrap) are written
// out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

   localparam int TICK   = 4;
   localparam int STABLE = 3;
   // Edges after reset release before the tick counter starts running.
   localparam int RST_STAGES = 2;
   // Hold time that always covers sync delay plus STABLE full ticks.
   localparam int HOLD = 4 * TICK;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] sw_raw = '0;
   logic [9:0] sw_stable;
   logic       ready;
   logic       change_pulse;
   logic [9:0] change_mask;
   logic       multi_change;
   logic [7:0] event_count;

   always #5 clk = ~clk;

   sw_debounce #(
      .TICK_CYCLES (TICK),
      .STABLE_TICKS(STABLE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_raw      (sw_raw),
      .sw_stable   (sw_stable),
      .ready       (ready),
      .change_pulse(change_pulse),
      .change_mask (change_mask),
      .multi_change(multi_change),
      .event_count (event_count)
   );

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int         edges = 0;
   logic [9:0] h1 = '0, h2 = '0;
   logic [9:0] m_stable = '0, m_mask = '0;
   logic       m_ready = 1'b0, m_multi = 1'b0, m_pulse = 1'b0, m_tick = 1'b0;
   logic [7:0] m_count = '0;
   int         run [10];

   task automatic model_step();
      logic [9:0] commits;
      if (!reset_n) begin
         edges = 0; h1 = '0; h2 = '0;
         m_stable = '0; m_mask = '0; m_ready = 1'b0; m_multi = 1'b0;
         m_pulse = 1'b0; m_tick = 1'b0; m_count = '0;
         for (int i = 0; i < 10; i++) run[i] = 0;
         return;
      end
      edges++;
      m_pulse = 1'b0;
      m_tick  = (edges > RST_STAGES) && (((edges - RST_STAGES) % TICK) == 0);
      if (m_tick) begin
         if (!m_ready) begin
            m_stable = h2;
            m_ready  = 1'b1;
         end else begin
            commits = '0;
            for (int i = 0; i < 10; i++) begin
               if (h2[i] != m_stable[i]) begin
                  run[i]++;
                  if (run[i] == STABLE) begin
                     commits[i] = 1'b1;
                     run[i]     = 0;
                  end
               end else begin
                  run[i] = 0;
               end
            end
            if (commits != '0) begin
               m_stable = m_stable ^ commits;
               m_mask   = commits;
               m_multi  = ($countones(commits) > 1);
               m_pulse  = 1'b1;
               m_count  = m_count + 8'd1;
            end
         end
      end
      // The level used at edge t is what sw_raw held at edge t-2.
      h2 = h1;
      h1 = sw_raw;
   endtask

   initial begin
      for (int i = 0; i < 10; i++) run[i] = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         model_step();
      end
   end

   // Cycle-by-cycle comparison against the model, away from the clock edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (change_pulse === 1'b1) pulses++;
         check("cyc_stable", 32'(sw_stable),    32'(m_stable));
         check("cyc_ready",  32'(ready),        32'(m_ready));
         check("cyc_pulse",  32'(change_pulse), 32'(m_pulse));
         check("cyc_mask",   32'(change_mask),  32'(m_mask));
         check("cyc_multi",  32'(multi_change), 32'(m_multi));
         check("cyc_count",  32'(event_count),  32'(m_count));
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the falling edge right after a model tick edge.
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tick && n < 100);
      if (!m_tick) begin
         checks++;
         failures++;
         $display("FAIL tick_wait: no tick within %0d cycles", n);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_stable"}, 32'(sw_stable),    32'h0);
      check({tag, "_ready"},  32'(ready),        32'h0);
      check({tag, "_pulse"},  32'(change_pulse), 32'h0);
      check({tag, "_mask"},   32'(change_mask),  32'h0);
      check({tag, "_multi"},  32'(multi_change), 32'h0);
      check({tag, "_count"},  32'(event_count),  32'h0);
   endtask

   typedef struct {
      logic [9:0] raw;
      logic [9:0] stable;
      logic [9:0] mask;
      logic       multi;
      logic [7:0] count;
      int         npulse;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int p0;
      int c0;

      // Hand-derived expectations, starting from a primed 10'h2A5, count 0.
      tbl[0] = '{raw: 10'h000, stable: 10'h000, mask: 10'h2A5, multi: 1'b1, count: 8'd1, npulse: 1};
      tbl[1] = '{raw: 10'h008, stable: 10'h008, mask: 10'h008, multi: 1'b0, count: 8'd2, npulse: 1};
      tbl[2] = '{raw: 10'h008, stable: 10'h008, mask: 10'h008, multi: 1'b0, count: 8'd2, npulse: 0};
      tbl[3] = '{raw: 10'h209, stable: 10'h209, mask: 10'h201, multi: 1'b1, count: 8'd3, npulse: 1};
      tbl[4] = '{raw: 10'h208, stable: 10'h208, mask: 10'h001, multi: 1'b0, count: 8'd4, npulse: 1};
      tbl[5] = '{raw: 10'h3FF, stable: 10'h3FF, mask: 10'h1F7, multi: 1'b1, count: 8'd5, npulse: 1};
      tbl[6] = '{raw: 10'h000, stable: 10'h000, mask: 10'h3FF, multi: 1'b1, count: 8'd6, npulse: 1};
      tbl[7] = '{raw: 10'h2A5, stable: 10'h2A5, mask: 10'h2A5, multi: 1'b1, count: 8'd7, npulse: 1};
      tbl[8] = '{raw: 10'h000, stable: 10'h000, mask: 10'h2A5, multi: 1'b1, count: 8'd8, npulse: 1};

      // ---- Power-up with switches at 10'h2A5 --------------------------------
      sw_raw  = 10'h2A5;
      reset_n = 1'b0;
      cycles(3);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      p0 = pulses;
      cycles(3 * TICK);
      check("prime_ready",  32'(ready),       32'h1);
      check("prime_stable", 32'(sw_stable),   32'h2A5);
      check("prime_count",  32'(event_count), 32'h0);
      check("prime_pulses", 32'(pulses - p0), 32'h0);

      // ---- Table of clean level changes -------------------------------------
      for (int v = 0; v < 9; v++) begin
         p0     = pulses;
         sw_raw = tbl[v].raw;
         cycles(HOLD);
         check($sformatf("vec%0d_stable", v), 32'(sw_stable),    32'(tbl[v].stable));
         check($sformatf("vec%0d_mask", v),   32'(change_mask),  32'(tbl[v].mask));
         check($sformatf("vec%0d_multi", v),  32'(multi_change), 32'(tbl[v].multi));
         check($sformatf("vec%0d_count", v),  32'(event_count),  32'(tbl[v].count));
         check($sformatf("vec%0d_pulses", v), 32'(pulses - p0),  32'(tbl[v].npulse));
      end

      // ---- Bounce on bit 0: high 1 tick, low 1 tick, then held high ---------
      wait_tick();
      p0     = pulses;
      sw_raw = 10'h001;
      cycles(TICK);
      sw_raw = 10'h000;
      cycles(TICK);
      sw_raw = 10'h001;
      check("bounce_no_pulse", 32'(pulses - p0), 32'h0);
      cycles(2 * TICK);
      check("bounce_tick2_stable", 32'(sw_stable), 32'h000);
      cycles(TICK);
      check("bounce_tick3_stable", 32'(sw_stable),    32'h001);
      check("bounce_pulses",       32'(pulses - p0),  32'h1);
      check("bounce_mask",         32'(change_mask),  32'h001);
      check("bounce_count",        32'(event_count),  32'd9);

      // ---- Reset two ticks into a pending change ----------------------------
      wait_tick();
      sw_raw = 10'h000;
      cycles(2 * TICK);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      sw_raw = 10'h3C0;
      cycles(3);
      reset_n = 1'b1;
      p0 = pulses;
      cycles(3 * TICK);
      check("reprime_ready",  32'(ready),        32'h1);
      check("reprime_stable", 32'(sw_stable),    32'h3C0);
      check("reprime_pulses", 32'(pulses - p0),  32'h0);
      check("reprime_count",  32'(event_count),  32'h0);
      check("reprime_mask",   32'(change_mask),  32'h0);

      // ---- 256 clean commits wrap event_count back to 0 ---------------------
      p0 = pulses;
      for (int k = 0; k < 256; k++) begin
         sw_raw = sw_raw ^ 10'h020;
         cycles(HOLD);
         if (k == 254) check("wrap_at_255", 32'(event_count), 32'd255);
      end
      check("wrap_count",  32'(event_count),  32'h0);
      check("wrap_pulses", 32'(pulses - p0),  32'd256);

      // ---- Randomized stimulus against the model ----------------------------
      for (int s = 0; s < 300; s++) begin
         c0 = int'($urandom_range(0, 99));
         if (c0 < 2) begin
            reset_n = 1'b0;
            cycles(2);
            reset_n = 1'b1;
         end else if (c0 < 25) begin
            sw_raw = 10'($urandom());
         end else begin
            sw_raw[$urandom_range(0, 9)] = ~sw_raw[$urandom_range(0, 9)];
         end
         cycles(int'($urandom_range(1, 24)));
      end
      cycles(HOLD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends on its own.
   initial begin
      #2_000_000;
      failures++;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter TICK_CYCLES, default 50000: clk cycles per sample tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter STABLE_TICKS, default 10: consecutive differing ticks required to accept a new level; legal range 2..255.
REQ-003 clk  input  1  system clock, 50 MHz board clock; all state is on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sw_raw  input  10  raw slide-switch levels; asynchronous to clk.
REQ-006 sw_stable  output  10  debounced switch levels, registered; feeds the switch-change detector and the arrangement checker.
REQ-007 ready  output  1  high once sw_stable holds a real sample after reset.
REQ-008 change_pulse  output  1  one-cycle strobe whenever sw_stable changes.
REQ-009 change_mask  output  10  bits of sw_stable that flipped on the last commit; held until the next commit.
REQ-010 multi_change  output  1  more than one bit set in change_mask; held with change_mask.
REQ-011 event_count  output  8  number of change_pulse strobes since reset.

Function
REQ-012 Each sw_raw bit SHALL pass through a two-flop synchronizer before any other use; sync[i] denotes the second-stage output.
REQ-013 A shared tick counter SHALL count 0..TICK_CYCLES-1 and wrap to 0; tick SHALL be high for exactly the one cycle in which the counter equals TICK_CYCLES-1.
REQ-014 The first tick after reset SHALL be a priming tick: sw_stable <= sync, ready <= 1. No change_pulse, change_mask or event_count update on the priming tick.
REQ-015 While ready=0, no bit SHALL commit and all per-bit counters SHALL stay at 0.
REQ-016 Per bit, on each tick with ready=1: if sync[i]==sw_stable[i], cnt[i] <= 0.
REQ-017 Per bit, on each tick with ready=1: if sync[i]!=sw_stable[i] and cnt[i]<STABLE_TICKS-1, cnt[i] <= cnt[i]+1.
REQ-018 Per bit, on each tick with ready=1: if sync[i]!=sw_stable[i] and cnt[i]==STABLE_TICKS-1, bit i commits: sw_stable[i] <= sync[i], cnt[i] <= 0.
REQ-019 A glitch shorter than one tick that is not sampled SHALL be invisible; a sampled reversion before the STABLE_TICKS-th differing tick SHALL clear cnt[i].
REQ-020 All bits committing on the same tick SHALL form one commit event.
REQ-021 A commit event SHALL load the committed bits into change_mask, raise change_pulse for one cycle, and set multi_change = (popcount(change_mask) > 1).
REQ-022 sw_stable, change_mask, multi_change and change_pulse SHALL all update on the same clock edge, so consumers see new data with the strobe.
REQ-023 No commit event on a tick SHALL mean change_pulse=0 and change_mask/multi_change unchanged.
REQ-024 Latency: a clean sw_raw edge SHALL reach sw_stable after 2 sync cycles plus STABLE_TICKS ticks (first tick partial).
REQ-025 event_count SHALL increment by 1 per change_pulse and wrap 255 -> 0 with no flag.
REQ-026 change_pulse SHALL never be high on two consecutive cycles; consecutive strobes are at least TICK_CYCLES apart.

Reset
REQ-027 reset_n low SHALL immediately clear all outputs: sw_stable=0, ready=0, change_pulse=0, change_mask=0, multi_change=0, event_count=0.
REQ-028 reset_n low SHALL immediately clear the synchronizer flops, tick counter and all cnt[i].
REQ-029 Reset asserted mid-count or mid-pulse SHALL abort all pending commits; after release the block re-primes per REQ-014.
REQ-030 Reset deassertion SHALL be synchronized to clk before it releases the tick counter.

Verification (TICK_CYCLES=4, STABLE_TICKS=3)
REQ-031 Power-up: sw_raw=10'h2A5, release reset -> on first tick ready=1, sw_stable=10'h2A5, change_pulse never high, event_count=0.
REQ-032 Clean toggle: from stable 10'h000, set sw_raw[3]=1 and hold -> sw_stable=10'h008 on the 3rd tick, change_mask=10'h008, multi_change=0, one pulse, event_count=1.
REQ-033 Bounce: toggle sw_raw[0] high for 1 tick, low for 1 tick, then high and held -> exactly one commit, 3 ticks after the final rise; no pulse from the bounce.
REQ-034 Simultaneous: sw_raw 10'h000 -> 10'h201 in one step -> single pulse, change_mask=10'h201, multi_change=1, event_count +1.
REQ-035 Wrap: produce 256 clean commits -> event_count returns to 0.
REQ-036 Reset mid-count: assert reset_n low 2 ticks into a pending change -> all outputs 0 at once; after release, re-prime with no pulse.
